// File: rtl/floatingpoint.sv
//------------------------------------------------------------------------------
// Module : floatingpoint (package)
// Brief  : Shared IEEE-754 single-precision types and constants.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package floatingpoint;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float;

  localparam logic [7:0]  EXP_MAX    = 8'hFF;
  localparam logic [23:0] HIDDEN_ONE = 24'h800000;

endpackage

`default_nettype wire

// File: rtl/addsub_n.sv
//------------------------------------------------------------------------------
// Module : addsub_n
// Brief  : W-bit two's-complement adder/subtractor with carry-out and zero flag.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module addsub_n
  import floatingpoint::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Sub,
  output logic [W-1:0] Result,
  output logic         Cout,
  output logic         Zero
);

  logic [W-1:0] w_bOperand;

  // Subtraction is A + ~B + 1, so Sub doubles as the carry-in.
  always_comb begin
    w_bOperand     = B ^ {W{Sub}};
    {Cout, Result} = {1'b0, A} + {1'b0, w_bOperand} + {{W{1'b0}}, Sub};
    Zero           = (Result == '0);
  end

endmodule

`default_nettype wire

// File: rtl/float_rounding.sv
//------------------------------------------------------------------------------
// Module : float_rounding
// Brief  : Round-to-nearest-even stage of the FloatAdder, one register bank.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module float_rounding
  import floatingpoint::*;
#(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              InValid,
  input  logic [MANT_W-1:0] normMant,
  input  logic [EXP_W-1:0]  currExp,
  input  logic              shiftRound,
  input  logic              sticky,
  output logic [MANT_W-1:0] roundMant,
  output logic [EXP_W-1:0]  roundExp,
  output logic              valid
);

  logic              w_inc;
  logic [MANT_W:0]   w_sumMant;
  logic              w_mantCout;
  logic              w_mantZero;
  logic [EXP_W-1:0]  w_expInc;
  logic              w_expCout;
  logic              w_expZero;
  logic [MANT_W-1:0] w_nextMant;
  logic [EXP_W-1:0]  w_nextExp;

  assign w_inc = shiftRound & (sticky | normMant[0]);

  addsub_n #(.W(MANT_W + 1)) u_mantInc (
    .A      ({1'b0, normMant}),
    .B      ({{MANT_W{1'b0}}, w_inc}),
    .Sub    (1'b0),
    .Result (w_sumMant),
    .Cout   (w_mantCout),
    .Zero   (w_mantZero)
  );

  addsub_n #(.W(EXP_W)) u_expInc (
    .A      (currExp),
    .B      ({{(EXP_W-1){1'b0}}, 1'b1}),
    .Sub    (1'b0),
    .Result (w_expInc),
    .Cout   (w_expCout),
    .Zero   (w_expZero)
  );

  // A carry out of the significand renormalises to 1.000..; at currExp=FE this
  // lands on exponent FF with a zero fraction, which is exactly Inf.
  always_comb begin
    w_nextMant = w_sumMant[MANT_W-1:0];
    w_nextExp  = currExp;
    if (currExp == EXP_MAX) begin
      w_nextMant = normMant;
      w_nextExp  = currExp;
    end else if (normMant == '0) begin
      w_nextMant = '0;
      w_nextExp  = '0;
    end else if (w_sumMant[MANT_W]) begin
      w_nextMant = w_sumMant[MANT_W:1];
      w_nextExp  = w_expInc;
    end
  end

  wire w_unused = &{1'b0, w_mantCout, w_mantZero, w_expCout, w_expZero};

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      roundMant <= '0;
      roundExp  <= '0;
      valid     <= 1'b0;
    end else if (InValid) begin
      roundMant <= w_nextMant;
      roundExp  <= w_nextExp;
      valid     <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_float_rounding.sv
//------------------------------------------------------------------------------
// Module : tb_float_rounding
// Brief  : Scoreboard bench for float_rounding against an arithmetic RNE model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_float_rounding;

  typedef struct packed {
    logic [23:0] mant;
    logic [7:0]  exp;
  } result_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        InValid = 1'b0;
  logic [23:0] normMant = '0;
  logic [7:0]  currExp = '0;
  logic        shiftRound = 1'b0;
  logic        sticky = 1'b0;
  logic [23:0] roundMant;
  logic [7:0]  roundExp;
  logic        valid;

  int nChecks = 0;
  int nFails  = 0;
  bit checkEn = 1'b0;

  result_t scoreboard[$];
  logic    mValid = 1'b0;
  result_t mExp   = '0;

  float_rounding #(.MANT_W(24), .EXP_W(8)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .InValid    (InValid),
    .normMant   (normMant),
    .currExp    (currExp),
    .shiftRound (shiftRound),
    .sticky     (sticky),
    .roundMant  (roundMant),
    .roundExp   (roundExp),
    .valid      (valid)
  );

  always #5 Clock = ~Clock;

  // Reference: value-level RNE on integers, then the IEEE special cases.
  function automatic result_t refModel(input logic [23:0] m, input logic [7:0] e,
                                       input logic g, input logic s);
    result_t r;
    int      sum;
    bit      odd;
    odd = (m % 2) == 1;
    if (e == 8'd255) begin
      r.mant = m;
      r.exp  = e;
    end else if (m == 0) begin
      r = '0;
    end else begin
      sum = int'(m) + ((g && (s || odd)) ? 1 : 0);
      if (sum >= (1 << 24)) begin
        r.mant = 24'(sum / 2);
        r.exp  = e + 8'd1;
      end else begin
        r.mant = 24'(sum);
        r.exp  = e;
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: tracks what the result registers should hold.
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mValid = 1'b0;
      mExp   = '0;
    end else if (InValid) begin
      if (scoreboard.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL sb_empty: launch with no expected entry at %0t", $time);
      end else begin
        mExp   = scoreboard.pop_front();
        mValid = 1'b1;
      end
    end
  end

  always @(negedge Clock) begin
    if (checkEn) begin
      check("valid", {31'b0, valid}, {31'b0, mValid});
      if (mValid) begin
        check("roundMant", {8'b0, roundMant}, {8'b0, mExp.mant});
        check("roundExp", {24'b0, roundExp}, {24'b0, mExp.exp});
      end
    end
  end

  task automatic launch(input logic [23:0] m, input logic [7:0] e,
                        input logic g, input logic s);
    @(negedge Clock);
    normMant   = m;
    currExp    = e;
    shiftRound = g;
    sticky     = s;
    InValid    = 1'b1;
    scoreboard.push_back(refModel(m, e, g, s));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clock);
      InValid    = 1'b0;
      normMant   = 24'($urandom);
      currExp    = 8'($urandom);
      shiftRound = 1'($urandom);
      sticky     = 1'($urandom);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] m;
    logic [7:0]  e;
    int          r;

    repeat (3) @(posedge Clock);
    #1;
    check("reset_valid", {31'b0, valid}, 32'd0);
    check("reset_mant", {8'b0, roundMant}, 32'd0);
    check("reset_exp", {24'b0, roundExp}, 32'd0);
    @(negedge Clock);
    #2 Reset = 1'b1;
    checkEn = 1'b1;
    idle(2);

    launch(24'hC00000, 8'h80, 1'b0, 1'b1);  idle(2);
    launch(24'h800001, 8'h7F, 1'b1, 1'b0);  idle(1);
    launch(24'h800002, 8'h7F, 1'b1, 1'b0);
    launch(24'hFFFFFF, 8'h7F, 1'b1, 1'b1);
    launch(24'hFFFFFF, 8'hFE, 1'b1, 1'b0);  idle(2);
    launch(24'h800000, 8'hFF, 1'b1, 1'b1);  idle(1);
    launch(24'h000000, 8'h40, 1'b1, 1'b1);  idle(2);

    // Asynchronous reset between edges while a result is being held.
    #2 Reset = 1'b0;
    #1;
    check("async_valid", {31'b0, valid}, 32'd0);
    check("async_mant", {8'b0, roundMant}, 32'd0);
    check("async_exp", {24'b0, roundExp}, 32'd0);
    @(negedge Clock);
    #2 Reset = 1'b1;
    idle(2);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      m = 24'h000000;
      else if (r == 1) m = 24'hFFFFFF;
      else             m = 24'h800000 | 24'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0)      e = 8'hFE;
      else if (r == 1) e = 8'hFF;
      else if (r == 2) e = 8'h7F;
      else             e = 8'($urandom_range(1, 254));
      if (e == 8'hFF && m == 24'h0) m = 24'h800000;
      launch(m, e, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(3);

    check("scoreboard_drained", scoreboard.size(), 32'd0);
    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

`default_nettype wire
